// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the processor execution controller.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        HALTED
    } exec_state_t;

    localparam logic MODE_RUN  = 1'b0;
    localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/step_debounce.sv
// Step push-button conditioning: 2-flop synchronizer, run-length debounce
// and rising-edge detector producing a one-cycle event.
module step_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);

    localparam int unsigned RUN_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic             filt_prev_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        run_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (run_q == RUN_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            run_q       <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            run_q       <= run_d;
        end
    end

    assign evt = filt_q & ~filt_prev_q;

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller: free-run / single-step clock enable for the core,
// with halt request, programmable cycle budget and executed-cycle counter.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_select,
    input  logic             clk_step,
    input  logic             start,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] cycle_limit,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic             running,
    output logic             halted,
    output logic             step_ack
);

    exec_state_t      state_q;
    exec_state_t      state_d;
    logic             sel_s1_q;
    logic             sel_s2_q;
    logic             step_evt;
    logic             budget_hit;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] limit_d;
    logic             cpu_en_q;
    logic             cpu_en_d;
    logic             ack_q;
    logic             ack_d;
    logic             running_q;
    logic             halted_q;

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk(clk),
        .rst(rst),
        .raw(clk_step),
        .evt(step_evt)
    );

    // The enabled cycle in progress is the last one allowed by the budget.
    assign budget_hit = cpu_en_q && (limit_q != '0) && (count_q == limit_q - CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        cpu_en_d = 1'b0;
        ack_d    = 1'b0;

        if (cpu_en_q && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            IDLE, HALTED: begin
                if (start && !((state_q == HALTED) && halt_req)) begin
                    count_d = '0;
                    limit_d = cycle_limit;
                    if (sel_s2_q == MODE_STEP) begin
                        state_d = STEP;
                    end else begin
                        state_d  = RUN;
                        cpu_en_d = 1'b1;
                    end
                end
            end
            RUN, STEP: begin
                if (halt_req || budget_hit) begin
                    state_d = HALTED;
                end else if (sel_s2_q == MODE_RUN) begin
                    state_d  = RUN;
                    cpu_en_d = 1'b1;
                end else begin
                    // Step events seen while still in RUN are dropped.
                    state_d  = STEP;
                    cpu_en_d = (state_q == STEP) && step_evt;
                    ack_d    = (state_q == STEP) && step_evt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sel_s1_q  <= 1'b0;
            sel_s2_q  <= 1'b0;
            count_q   <= '0;
            limit_q   <= '0;
            cpu_en_q  <= 1'b0;
            ack_q     <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_s1_q  <= clk_select;
            sel_s2_q  <= sel_s1_q;
            count_q   <= count_d;
            limit_q   <= limit_d;
            cpu_en_q  <= cpu_en_d;
            ack_q     <= ack_d;
            running_q <= (state_d == RUN) || (state_d == STEP);
            halted_q  <= (state_d == HALTED);
        end
    end

    assign cpu_en      = cpu_en_q;
    assign step_ack    = ack_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed scenarios plus a random phase,
// all compared every cycle against a behavioural model built on input histories.
module tb_exec_ctrl;

    localparam int unsigned DB   = 4;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;
    localparam int          HL   = 16;
    localparam int          P_IDLE = 0;
    localparam int          P_RUN  = 1;
    localparam int          P_STEP = 2;
    localparam int          P_HALT = 3;

    logic          clk         = 1'b0;
    logic          rst         = 1'b0;
    logic          clk_select  = 1'b0;
    logic          clk_step    = 1'b0;
    logic          start       = 1'b0;
    logic          halt_req    = 1'b0;
    logic [CW-1:0] cycle_limit = '0;
    logic          cpu_en;
    logic [CW-1:0] cycle_count;
    logic          running;
    logic          halted;
    logic          step_ack;

    int checks   = 0;
    int failures = 0;
    int en_seen  = 0;

    // Behavioural model state
    int m_phase;
    bit m_en;
    bit m_ack;
    int m_cnt;
    int m_lim;
    bit sel_h  [HL];
    bit stp_h  [HL];
    bit filt1;
    bit filt2;

    always #5 clk = ~clk;

    exec_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_select(clk_select),
        .clk_step(clk_step),
        .start(start),
        .halt_req(halt_req),
        .cycle_limit(cycle_limit),
        .cpu_en(cpu_en),
        .cycle_count(cycle_count),
        .running(running),
        .halted(halted),
        .step_ack(step_ack)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_en    = 1'b0;
        m_ack   = 1'b0;
        m_cnt   = 0;
        m_lim   = 0;
        for (int i = 0; i < HL; i++) begin
            sel_h[i] = 1'b0;
            stp_h[i] = 1'b0;
        end
        filt1 = 1'b0;
        filt2 = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs visible at that edge.
    task automatic model_edge();
        bit mode;
        bit evt;
        bit flip;
        bit hit;
        int nxt_cnt;
        for (int i = HL - 1; i > 0; i--) begin
            sel_h[i] = sel_h[i-1];
            stp_h[i] = stp_h[i-1];
        end
        sel_h[0] = clk_select;
        stp_h[0] = clk_step;
        // Decisions at this edge see the inputs from two edges ago.
        mode = sel_h[2];
        evt  = filt1 && !filt2;
        flip = 1'b1;
        for (int j = 0; j < int'(DB); j++) begin
            if (stp_h[2+j] == filt1) flip = 1'b0;
        end
        filt2 = filt1;
        if (flip) filt1 = !filt1;

        hit     = m_en && (m_lim != 0) && (m_cnt + 1 == m_lim);
        nxt_cnt = (m_en && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
        m_ack   = 1'b0;
        if (m_phase == P_IDLE || m_phase == P_HALT) begin
            m_en = 1'b0;
            if (start && !(m_phase == P_HALT && halt_req)) begin
                nxt_cnt = 0;
                m_lim   = int'(cycle_limit);
                m_phase = mode ? P_STEP : P_RUN;
                m_en    = !mode;
            end
        end else if (halt_req || hit) begin
            m_phase = P_HALT;
            m_en    = 1'b0;
        end else if (!mode) begin
            m_phase = P_RUN;
            m_en    = 1'b1;
        end else begin
            m_en    = (m_phase == P_STEP) && evt;
            m_ack   = m_en;
            m_phase = P_STEP;
        end
        m_cnt = nxt_cnt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        check_eq("cpu_en",      int'(cpu_en),      int'(m_en));
        check_eq("step_ack",    int'(step_ack),    int'(m_ack));
        check_eq("running",     int'(running),     int'(m_phase == P_RUN || m_phase == P_STEP));
        check_eq("halted",      int'(halted),      int'(m_phase == P_HALT));
        check_eq("cycle_count", int'(cycle_count), m_cnt);
        if (cpu_en) en_seen++;
    endtask

    task automatic pulse_start(input int lim);
        cycle_limit = CW'(lim);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int hold);
        clk_step = 1'b1;
        ticks(hold);
        clk_step = 1'b0;
        ticks(hold);
    endtask

    initial begin
        int first_en;
        int base;

        model_reset();
        ticks(3);
        check_eq("reset_cpu_en",  int'(cpu_en),      0);
        check_eq("reset_count",   int'(cycle_count), 0);
        rst = 1'b1;
        ticks(2);

        // Free-run, unlimited: 51 enabled cycles up to and including the halt cycle
        pulse_start(0);
        check_eq("start_latency", int'(cpu_en), 1);
        ticks(50);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_eq("freerun_count",  int'(cycle_count), 51);
        check_eq("freerun_halted", int'(halted),      1);
        check_eq("freerun_cpu_en", int'(cpu_en),      0);

        // Cycle budget of 10
        en_seen = 0;
        pulse_start(10);
        ticks(30);
        check_eq("budget_en_cycles", en_seen,          10);
        check_eq("budget_count",     int'(cycle_count), 10);
        check_eq("budget_halted",    int'(halted),      1);
        pulse_start(0);
        check_eq("restart_count", int'(cycle_count), 0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;

        // Halt and budget in the same cycle, then start ignored while halt held
        pulse_start(5);
        ticks(4);
        halt_req = 1'b1;
        tick();
        check_eq("both_halted", int'(halted),      1);
        check_eq("both_count",  int'(cycle_count), 5);
        pulse_start(0);
        check_eq("start_ignored_halted", int'(halted),      1);
        check_eq("start_ignored_count",  int'(cycle_count), 5);
        halt_req = 1'b0;
        tick();

        // Counter saturation
        pulse_start(0);
        ticks(300);
        check_eq("saturate_count", int'(cycle_count), CMAX);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;

        // Bouncy step button in single-step mode
        clk_select = 1'b1;
        ticks(3);
        pulse_start(0);
        check_eq("step_entry_running", int'(running), 1);
        en_seen = 0;
        for (int i = 0; i < 6; i++) begin
            clk_step = (i % 2 == 0);
            tick();
        end
        clk_step = 1'b1;
        first_en = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_en && first_en < 0) first_en = i;
        end
        check_eq("bounce_pulses",  en_seen,           1);
        check_eq("bounce_latency", first_en,          int'(DB) + 3);
        check_eq("bounce_count",   int'(cycle_count), 1);
        clk_step = 1'b0;
        ticks(12);

        // Mode switch mid-run, then two clean presses
        halt_req = 1'b1;
        tick();
        halt_req   = 1'b0;
        clk_select = 1'b0;
        ticks(3);
        pulse_start(0);
        ticks(4);
        clk_select = 1'b1;
        ticks(2);
        check_eq("mode_still_en", int'(cpu_en), 1);
        tick();
        check_eq("mode_en_drop",  int'(cpu_en),  0);
        check_eq("mode_step_run", int'(running), 1);
        base = int'(cycle_count);
        press(10);
        press(10);
        check_eq("two_presses", int'(cycle_count), base + 2);

        // Asynchronous reset in the middle of a RUN cycle
        clk_select = 1'b0;
        ticks(4);
        check_eq("pre_reset_run", int'(cpu_en), 1);
        #3 rst = 1'b0;
        #1;
        check_eq("async_rst_cpu_en",  int'(cpu_en),      0);
        check_eq("async_rst_running", int'(running),     0);
        check_eq("async_rst_halted",  int'(halted),      0);
        check_eq("async_rst_ack",     int'(step_ack),    0);
        check_eq("async_rst_count",   int'(cycle_count), 0);
        model_reset();
        ticks(2);
        rst = 1'b1;
        en_seen = 0;
        press(12);
        check_eq("idle_step_dropped", en_seen,       0);
        check_eq("idle_not_running",  int'(running), 0);

        // Random phase
        for (int c = 0; c < 600; c++) begin
            start    = ($urandom_range(0, 15) == 0);
            halt_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) clk_select = ~clk_select;
            if ($urandom_range(0, 7) == 0)  clk_step   = ~clk_step;
            cycle_limit = CW'($urandom_range(0, 24));
            tick();
        end
        start    = 1'b0;
        halt_req = 1'b0;
        ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
